// File: rtl/gfx_pkg.sv
// Shared types and constants for the line raster sequencer and its helpers.
package gfx_pkg;

  localparam int FRAC_BITS    = 16;
  localparam int COORD_W      = 16;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic signed [31:0] q16_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    BOX,
    ISSUE,
    WAIT,
    WRITE,
    ADVANCE,
    DONE
  } state_t;

endpackage

// File: rtl/line_raster_sequencer_bbox_clamp.sv
// One axis of the bounding box: floor both ends, widen by the margin,
// then intersect with the screen range [0, LIMIT].
module bbox_clamp
  import gfx_pkg::*;
#(
  parameter int MARGIN = 5,
  parameter int LIMIT  = 639
) (
  input  q16_t               a,
  input  q16_t               b,
  output logic [COORD_W-1:0] lo,
  output logic [COORD_W-1:0] hi,
  output logic               empty
);

  q16_t mn_s, mx_s, lo_pix_s, hi_pix_s, lo_c_s, hi_c_s;

  // Each bound is clamped only on its own side so a fully off-screen
  // axis yields lo > hi rather than a single edge pixel.
  always_comb begin
    if (a < b) begin
      mn_s = a;
      mx_s = b;
    end else begin
      mn_s = b;
      mx_s = a;
    end
    lo_pix_s = (mn_s >>> FRAC_BITS) - 32'(MARGIN);
    hi_pix_s = (mx_s >>> FRAC_BITS) + 32'(MARGIN);
    if (lo_pix_s < 32'sd0) begin
      lo_c_s = 32'sd0;
    end else begin
      lo_c_s = lo_pix_s;
    end
    if (hi_pix_s > 32'(LIMIT)) begin
      hi_c_s = 32'(LIMIT);
    end else begin
      hi_c_s = hi_pix_s;
    end
    empty = (lo_c_s > hi_c_s);
    lo    = COORD_W'(lo_c_s);
    hi    = COORD_W'(hi_c_s);
  end

endmodule

// File: rtl/line_raster_sequencer.sv
// Scans the clamped bounding box of one line command, testing each pixel with
// the shared pixel_on_line tester and writing hits to the framebuffer.
module line_raster_sequencer
  import gfx_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int LINE_WIDTH = 5,
  parameter int COLOR_W    = 12,
  parameter int ADDR_W     = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic signed [31:0]  cmd_x0,
  input  logic signed [31:0]  cmd_y0,
  input  logic signed [31:0]  cmd_xn,
  input  logic signed [31:0]  cmd_yn,
  input  logic signed [31:0]  cmd_mag,
  input  logic [COLOR_W-1:0]  cmd_color,
  output logic signed [31:0]  pol_x,
  output logic signed [31:0]  pol_y,
  output logic signed [31:0]  pol_x0,
  output logic signed [31:0]  pol_y0,
  output logic signed [31:0]  pol_xn,
  output logic signed [31:0]  pol_yn,
  output logic signed [31:0]  pol_mag,
  output logic                pol_start,
  input  logic                pol_on_line,
  input  logic                pol_we,
  output logic                fb_wr_valid,
  input  logic                fb_wr_ready,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOR_W-1:0]  fb_data,
  output logic                busy,
  output logic                done
);

  state_t state_q, state_d;
  q16_t   x0_q, x0_d, y0_q, y0_d, xn_q, xn_d, yn_q, yn_d, mag_q, mag_d;
  q16_t   x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic [COORD_W-1:0] xlo_s, xhi_s, ylo_s, yhi_s;
  logic               xempty_s, yempty_s;

  bbox_clamp #(.MARGIN(LINE_WIDTH), .LIMIT(SCREEN_W - 1)) u_clamp_x (
    .a(x0_q), .b(x1_q), .lo(xlo_s), .hi(xhi_s), .empty(xempty_s)
  );

  bbox_clamp #(.MARGIN(LINE_WIDTH), .LIMIT(SCREEN_H - 1)) u_clamp_y (
    .a(y0_q), .b(y1_q), .lo(ylo_s), .hi(yhi_s), .empty(yempty_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    xn_d    = xn_q;
    yn_d    = yn_q;
    mag_d   = mag_q;
    color_d = color_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    px_d    = px_q;
    py_d    = py_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          xn_d    = cmd_xn;
          yn_d    = cmd_yn;
          mag_d   = cmd_mag;
          color_d = cmd_color;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        // Full 64-bit signed product, keeping the Q16.16 window [47:16].
        x1_d    = x0_q + 32'((64'(xn_q) * 64'(mag_q)) >>> FRAC_BITS);
        y1_d    = y0_q + 32'((64'(yn_q) * 64'(mag_q)) >>> FRAC_BITS);
        state_d = BOX;
      end
      BOX: begin
        if (xempty_s || yempty_s) begin
          state_d = DONE;
        end else begin
          xmin_d  = xlo_s;
          xmax_d  = xhi_s;
          ymin_d  = ylo_s;
          ymax_d  = yhi_s;
          px_d    = xlo_s;
          py_d    = ylo_s;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (pol_we) begin
          state_d = pol_on_line ? WRITE : ADVANCE;
        end else begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        if (fb_wr_ready) begin
          state_d = ADVANCE;
        end else begin
          state_d = WRITE;
        end
      end
      ADVANCE: begin
        if (px_q < xmax_q) begin
          px_d    = px_q + COORD_W'(1'b1);
          state_d = ISSUE;
        end else if (py_q < ymax_q) begin
          px_d    = xmin_q;
          py_d    = py_q + COORD_W'(1'b1);
          state_d = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      xn_q    <= '0;
      yn_q    <= '0;
      mag_q   <= '0;
      color_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xn_q    <= xn_d;
      yn_q    <= yn_d;
      mag_q   <= mag_d;
      color_q <= color_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign pol_start   = (state_q == ISSUE);
  assign fb_wr_valid = (state_q == WRITE);
  assign pol_x       = {px_q, 16'h0000};
  assign pol_y       = {py_q, 16'h0000};
  assign pol_x0      = x0_q;
  assign pol_y0      = y0_q;
  assign pol_xn      = xn_q;
  assign pol_yn      = yn_q;
  assign pol_mag     = mag_q;
  assign fb_addr     = ADDR_W'(py_q) * ADDR_W'(SCREEN_W) + ADDR_W'(px_q);
  assign fb_data     = color_q;

endmodule
